idu_ctrl: RTL and testbench

IDU_CTRL -- requirements
Module: idu_ctrl

---
 rtl/idu_ctrl.sv | 128 ++++++++++++
 tb/tb_idu_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_ctrl.sv
// Instruction decode buffer: 2-entry FIFO between fetch and execute that decodes
// RV32I instruction type and immediate on enqueue and presents the head entry.
module idu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [5:0]  out_type,
    output logic        out_illegal
);

    localparam logic [5:0] TYPE_R = 6'b000001;
    localparam logic [5:0] TYPE_I = 6'b000010;
    localparam logic [5:0] TYPE_S = 6'b000100;
    localparam logic [5:0] TYPE_B = 6'b001000;
    localparam logic [5:0] TYPE_U = 6'b010000;
    localparam logic [5:0] TYPE_J = 6'b100000;

    logic [31:0] inst_q [2];
    logic [31:0] pc_q   [2];
    logic [31:0] imm_q  [2];
    logic [5:0]  type_q [2];
    logic        ill_q  [2];

    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic [31:0] dec_imm;
    logic [5:0]  dec_type;
    logic        dec_ill;

    // Returns {illegal, type, imm}; unknown opcodes (incl. compressed) give illegal with zero type/imm.
    function automatic logic [38:0] decode(input logic [31:0] inst);
        logic [31:0] imm;
        logic [5:0]  typ;
        logic        ill;
        imm = '0;
        typ = '0;
        ill = 1'b0;
        case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                typ = TYPE_I;
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                typ = TYPE_S;
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                typ = TYPE_B;
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                typ = TYPE_U;
                imm = {inst[31:12], 12'b0};
            end
            7'b1101111: begin
                typ = TYPE_J;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b0110011: typ = TYPE_R;
            default:    ill = 1'b1;
        endcase
        return {ill, typ, imm};
    endfunction

    assign {dec_ill, dec_type, dec_imm} = decode(in_inst);

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
                type_q[i] <= '0;
                ill_q[i]  <= 1'b0;
            end
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                inst_q[tail] <= in_inst;
                pc_q[tail]   <= in_pc;
                imm_q[tail]  <= dec_imm;
                type_q[tail] <= dec_type;
                ill_q[tail]  <= dec_ill;
                tail         <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_inst    = inst_q[head];
    assign out_pc      = pc_q[head];
    assign out_imm     = imm_q[head];
    assign out_type    = type_q[head];
    assign out_illegal = ill_q[head];

endmodule

// File: tb/tb_idu_ctrl.sv
// Self-checking bench for idu_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based reference model with an arithmetic decoder.
module tb_idu_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [5:0]  out_type;
    logic        out_illegal;

    int checks = 0;
    int failures = 0;

    logic [31:0] mq_inst[$];
    logic [31:0] mq_pc[$];

    idu_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm),
        .out_type(out_type), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: {illegal, type, imm} derived from the field layout with integer arithmetic.
    function automatic logic [38:0] ref_decode(input logic [31:0] inst);
        int v;
        int idx;
        logic [31:0] imm;
        v = 0;
        idx = -1;
        case (inst[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin
                idx = 1;
                v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            end
            7'h23: begin
                idx = 2;
                v = int'(inst[31:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 4096 : 0);
            end
            7'h63: begin
                idx = 3;
                v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
                    - (inst[31] ? 4096 : 0);
            end
            7'h37, 7'h17: begin
                idx = 4;
                v = int'(inst & 32'hFFFF_F000);
            end
            7'h6F: begin
                idx = 5;
                v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
                    - (inst[31] ? (1 << 20) : 0);
            end
            7'h33: idx = 0;
            default: idx = -1;
        endcase
        imm = 32'(v);
        if (idx < 0) return {1'b1, 6'd0, 32'd0};
        return {1'b0, 6'(1 << idx), imm};
    endfunction

    // Advance one clock, updating the model with the transfers the current inputs imply.
    task automatic tick();
        logic push;
        logic pop;
        push = in_valid && (mq_inst.size() < 2) && !flush;
        pop  = (mq_inst.size() > 0) && out_ready && !flush;
        @(posedge clk);
        if (flush || rst) begin
            mq_inst.delete();
            mq_pc.delete();
        end else begin
            if (pop) begin
                void'(mq_inst.pop_front());
                void'(mq_pc.pop_front());
            end
            if (push) begin
                mq_inst.push_back(in_inst);
                mq_pc.push_back(in_pc);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h100;
        out_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_hs: got valid/ready=%b want 01", {out_valid, in_ready});
        end
        checks++;
        if ({out_inst, out_pc, out_imm, out_type, out_illegal} !== 103'd0) begin
            failures++;
            $display("FAIL reset_data: got inst=%h pc=%h imm=%h type=%b ill=%b want all 0",
                     out_inst, out_pc, out_imm, out_type, out_illegal);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_inst = 32'hFFF0_0093; in_pc = 32'h0000_1000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_inst, out_pc, out_imm, out_type, out_illegal} !==
            {1'b1, 32'hFFF0_0093, 32'h0000_1000, 32'hFFFF_FFFF, 6'b000010, 1'b0}) begin
            failures++;
            $display("FAIL addi: got v=%b inst=%h pc=%h imm=%h type=%b ill=%b want v=1 imm=ffffffff type=000010",
                     out_valid, out_inst, out_pc, out_imm, out_type, out_illegal);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL addi_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] insts [3];
        logic [31:0] imms  [3];
        logic [5:0]  types [3];
        insts = '{32'h0011_2623, 32'h1234_5537, 32'hFFDF_F06F};
        imms  = '{32'h0000_000C, 32'h1234_5000, 32'hFFFF_FFFC};
        types = '{6'b000100, 6'b010000, 6'b100000};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h2000 + 32'(4 * i);
            tick();
            checks++;
            if ({out_valid, out_inst, out_pc, out_imm, out_type} !==
                {1'b1, insts[i], 32'h2000 + 32'(4 * i), imms[i], types[i]}) begin
                failures++;
                $display("FAIL seq%0d: got v=%b inst=%h pc=%h imm=%h type=%b want inst=%h imm=%h type=%b",
                         i, out_valid, out_inst, out_pc, out_imm, out_type, insts[i], imms[i], types[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 32'h3000;
        tick();
        in_inst = 32'h0020_8133; in_pc = 32'h3004;
        tick();
        in_inst = 32'h0000_0097; in_pc = 32'h3008;
        checks++;
        if ({in_ready, out_valid, out_inst} !== {1'b0, 1'b1, 32'h0000_0013}) begin
            failures++;
            $display("FAIL b2b_full: got ready=%b valid=%b inst=%h want 0 1 00000013", in_ready, out_valid, out_inst);
        end
        tick();
        checks++;
        if ({in_ready, out_inst, out_pc} !== {1'b0, 32'h0000_0013, 32'h3000}) begin
            failures++;
            $display("FAIL b2b_hold: got ready=%b inst=%h pc=%h want 0 00000013 3000", in_ready, out_inst, out_pc);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_inst, out_pc} !== {1'b1, 32'h0020_8133, 32'h3004}) begin
            failures++;
            $display("FAIL b2b_deq: got ready=%b inst=%h pc=%h want 1 00208133 3004", in_ready, out_inst, out_pc);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_inst, out_pc, out_type} !== {1'b1, 32'h0000_0097, 32'h3008, 6'b010000}) begin
            failures++;
            $display("FAIL b2b_third: got v=%b inst=%h pc=%h type=%b want 1 00000097 3008 010000",
                     out_valid, out_inst, out_pc, out_type);
        end
        tick();
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h0000_007F; in_pc = 32'h4000;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_illegal, out_type, out_imm, out_inst} !== {1'b1, 1'b1, 6'd0, 32'd0, 32'h0000_007F}) begin
            failures++;
            $display("FAIL illegal: got v=%b ill=%b type=%b imm=%h inst=%h want 1 1 0 0 0000007f",
                     out_valid, out_illegal, out_type, out_imm, out_inst);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_inst = 32'h0000_0013 | (32'(i + 1) << 20); in_pc = 32'h5000 + 32'(4 * i);
            tick();
        end
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL flush_full: got valid/ready=%b want 10", {out_valid, in_ready});
        end
        flush = 1'b1; in_inst = 32'h0000_0033; in_pc = 32'h5008; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_clear: got valid/ready=%b want 01", {out_valid, in_ready});
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_nodeliver: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0000_0013; in_pc = 32'h6000;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got out_valid=%b want 1", out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, out_inst} !== {1'b0, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL areset_now: got valid=%b ready=%b inst=%h want 0 1 0", out_valid, in_ready, out_inst);
        end
        mq_inst.delete();
        mq_pc.delete();
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL areset_after: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12];
        logic [31:0] r;
        logic [38:0] exp_dec;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h12};
        for (int c = 0; c < 400; c++) begin
            r = $urandom();
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_inst   = {r[31:7], ops[$urandom_range(0, 11)]};
            in_pc     = $urandom() & 32'hFFFF_FFFC;
            checks++;
            if ({out_valid, in_ready} !== {mq_inst.size() != 0, mq_inst.size() < 2}) begin
                failures++;
                $display("FAIL rand_hs cyc%0d: got valid/ready=%b%b want occupancy %0d",
                         c, out_valid, in_ready, mq_inst.size());
            end
            if (mq_inst.size() != 0) begin
                exp_dec = ref_decode(mq_inst[0]);
                checks++;
                if ({out_inst, out_pc, out_illegal, out_type, out_imm} !== {mq_inst[0], mq_pc[0], exp_dec}) begin
                    failures++;
                    $display("FAIL rand_head cyc%0d: got inst=%h pc=%h ill=%b type=%b imm=%h want inst=%h pc=%h ill=%b type=%b imm=%h",
                             c, out_inst, out_pc, out_illegal, out_type, out_imm,
                             mq_inst[0], mq_pc[0], exp_dec[38], exp_dec[37:32], exp_dec[31:0]);
                end
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        #1;
        test_reset();
        test_addi();
        test_sequence();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
